// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and a buffered long-latency unit,
// with a pending-rd scoreboard and starvation drain. Optional same-cycle bypass: RFARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_id,
  input  logic [31:0]              wb_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_id,
  input  logic [31:0]              lu_data,
  input  logic                     issue_en,
  input  logic [4:0]               issue_id,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     stall,
  output logic                     rf_we,
  output logic [4:0]               rf_id,
  output logic [31:0]              rf_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [36:0]       mem_q [DEPTH];
  logic [36:0]       mem_d [DEPTH];
  logic [31:0]       pending_q, pending_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_id_q, rf_id_d;
  logic [31:0]       rf_data_q, rf_data_d;

  logic              wb_grant, fifo_empty, pop, push, bypass;
  logic [4:0]        head_id;
  logic [31:0]       head_data;

  always_comb begin
    wb_grant   = wb_we && (wb_id != 5'd0);
    fifo_empty = (count_q == '0);
    pop        = !wb_grant && !fifo_empty;
    lu_ready   = (count_q < CW'(DEPTH));
`ifdef RFARB_BYPASS_EN
    bypass     = lu_valid && fifo_empty && !wb_we && (lu_id != 5'd0);
`else
    bypass     = 1'b0;
`endif
    // Results for x0 are accepted but dropped rather than occupying a slot.
    push       = lu_valid && lu_ready && (lu_id != 5'd0) && !bypass;
    head_id    = mem_q[rd_ptr_q][36:32];
    head_data  = mem_q[rd_ptr_q][31:0];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {lu_id, lu_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_id_d   = 5'd0;
    rf_data_d = 32'd0;
    pending_d = pending_q;
    if (wb_grant) begin
      rf_we_d   = 1'b1;
      rf_id_d   = wb_id;
      rf_data_d = wb_data;
    end else if (pop) begin
      rf_we_d   = 1'b1;
      rf_id_d   = head_id;
      rf_data_d = head_data;
    end else if (bypass) begin
      rf_we_d   = 1'b1;
      rf_id_d   = lu_id;
      rf_data_d = lu_data;
    end
    if (pop) pending_d[head_id] = 1'b0;
    if (bypass) pending_d[lu_id] = 1'b0;
    // The set is applied last so a same-cycle issue overrides a retire.
    if (issue_en && (issue_id != 5'd0)) pending_d[issue_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (fifo_empty || pop) begin
          starve_d = '0;
        end else if (starve_q == SW'(STARVE_MAX - 1)) begin
          starve_d = '0;
          state_d  = DRAIN;
        end else begin
          starve_d = starve_q + SW'(1);
        end
      end
      DRAIN: begin
        starve_d = '0;
        if (fifo_empty) state_d = IDLE;
      end
      default: begin
        starve_d = '0;
        state_d  = IDLE;
      end
    endcase
    stall_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_id_q   <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      rf_we_q   <= rf_we_d;
      rf_id_q   <= rf_id_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rs1_busy   = (rs1 != 5'd0) && pending_q[rs1];
  assign rs2_busy   = (rs2 != 5'd0) && pending_q[rs2];
  assign stall      = stall_q;
  assign rf_we      = rf_we_q;
  assign rf_id      = rf_id_q;
  assign rf_data    = rf_data_q;
  assign fifo_count = count_q;

endmodule
